// File: rtl/gbsha_fir_driver.sv
// Drives a 2-tap FIR through its reset/word pins: clear, load c1 then c0, stream
// buffered samples (bubbles on underflow), then flush the delay line.
module gbsha_fir_driver #(
  parameter int BW_in      = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [BW_in-1:0] cfg_c0,
  input  logic [BW_in-1:0] cfg_c1,
  input  logic [7:0]       cfg_len,
  input  logic             s_valid,
  input  logic [BW_in-1:0] s_data,
  output logic             s_ready,
  output logic             fir_reset,
  output logic [BW_in-1:0] fir_x,
  output logic             busy,
  output logic             done,
  output logic [7:0]       underflow_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RST    = 3'd1,
    LOAD1  = 3'd2,
    LOAD0  = 3'd3,
    STREAM = 3'd4,
    DRAIN  = 3'd5
  } state_t;

  state_t           state;
  logic [BW_in-1:0] c0_q;
  logic [BW_in-1:0] c1_q;
  logic [7:0]       len_q;
  logic [7:0]       smp_cnt;
  logic             drain_cnt;

  // Sample buffer; the extra pointer bit separates full from empty.
  logic [BW_in-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop_req;
  logic             pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign s_ready = !full;
  assign push    = s_valid && s_ready;

  // A word is due at the coming edge whenever the next state is STREAM.
  assign pop_req = ((state == LOAD0) && (len_q != 8'd0)) ||
                   ((state == STREAM) && (smp_cnt != len_q));
  assign pop     = pop_req && !empty;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Outputs are loaded with the values of the state being entered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      fir_reset     <= 1'b1;
      fir_x         <= '0;
      done          <= 1'b0;
      underflow_cnt <= 8'd0;
      c0_q          <= '0;
      c1_q          <= '0;
      len_q         <= 8'd0;
      smp_cnt       <= 8'd0;
      drain_cnt     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          fir_reset <= 1'b1;
          fir_x     <= '0;
          if (start) begin
            c0_q          <= cfg_c0;
            c1_q          <= cfg_c1;
            len_q         <= cfg_len;
            underflow_cnt <= 8'd0;
            state         <= RST;
          end
        end
        RST: begin
          state     <= LOAD1;
          fir_reset <= 1'b0;
          fir_x     <= c1_q;
        end
        LOAD1: begin
          state   <= LOAD0;
          fir_x   <= c0_q;
          smp_cnt <= 8'd0;
        end
        LOAD0, STREAM: begin
          if (pop_req) begin
            state   <= STREAM;
            smp_cnt <= smp_cnt + 8'd1;
            if (empty) begin
              fir_x <= '0;
              if (underflow_cnt != 8'hFF) underflow_cnt <= underflow_cnt + 8'd1;
            end else begin
              fir_x <= mem[rd_ptr[AW-1:0]];
            end
          end else begin
            state     <= DRAIN;
            fir_x     <= '0;
            drain_cnt <= 1'b0;
          end
        end
        DRAIN: begin
          fir_x <= '0;
          if (drain_cnt) begin
            state     <= IDLE;
            fir_reset <= 1'b1;
            done      <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          fir_reset <= 1'b1;
          fir_x     <= '0;
        end
      endcase
    end
  end

endmodule
